fifo_sample_reader: RTL and testbench



---
 rtl/fifo_sample_reader_if.sv | 21 ++
 rtl/fifo_sample_reader.sv | 171 +++++++++++++++++
 tb/tb_fifo_sample_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sample_reader_if.sv
// FIFO-side signal bundle for fifo_sample_reader: read pulse, read data and
// the monitored write strobe. The reader uses "master", the FIFO/model uses "slave".
interface fifo_sample_reader_if #(
    parameter int WIDTH = 16
);
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_wr_mon;

    modport master (
        output fifo_rd,
        input  fifo_dout,
        input  fifo_wr_mon
    );

    modport slave (
        input  fifo_rd,
        output fifo_dout,
        output fifo_wr_mon
    );
endinterface

// File: rtl/fifo_sample_reader.sv
// Drains one FIFO sample per sample period, tracking occupancy from the write strobe.
// Optional macro SAMPLE_HOLD_EN: on underrun keep the previous sample instead of forcing 0.
module fifo_sample_reader #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 512,
    parameter int SAMPLE_PERIOD = 2268,
    parameter int RD_LAT        = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clr_overflow,
    fifo_sample_reader_if.master       fif,
    output logic [WIDTH-1:0]           sample_out,
    output logic                       sample_strobe,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       underrun,
    output logic                       overflow
);
    localparam int LW        = $clog2(DEPTH + 1);
    localparam int TW        = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WCW       = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam int WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_STROBE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             wr_prev_q, wr_prev_d;
    logic             fifo_rd_q, fifo_rd_d;
    logic [WIDTH-1:0] sample_out_q, sample_out_d;
    logic             sample_strobe_q, sample_strobe_d;
    logic [LW-1:0]    level_q, level_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;

    logic tick_s, wr_edge_s, dec_s, ovf_set_s;

    // Timer, write-edge detect and occupancy/overflow bookkeeping.
    always_comb begin
        tick_s    = enable && (timer_q == TW'(SAMPLE_PERIOD - 1));
        wr_edge_s = fif.fifo_wr_mon && !wr_prev_q;
        dec_s     = (state_q == S_REQ);
        ovf_set_s = wr_edge_s && !dec_s && (level_q == LW'(DEPTH));
        wr_prev_d = fif.fifo_wr_mon;

        if (!enable) begin
            timer_d = timer_q;
        end else if (tick_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // A write coinciding with the read decrement cancels out.
        if (wr_edge_s && !dec_s) begin
            if (level_q == LW'(DEPTH)) begin
                level_d = level_q;
            end else begin
                level_d = level_q + LW'(1);
            end
        end else if (!wr_edge_s && dec_s && (level_q != '0)) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end

        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Fetch sequencer: next state, sample word, strobe and underrun.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        sample_out_d    = sample_out_q;
        sample_strobe_d = 1'b0;
        underrun_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick_s) begin
                    if (level_q != '0) begin
                        state_d = S_REQ;
                    end else begin
                        underrun_d      = 1'b1;
                        sample_strobe_d = 1'b1;
`ifdef SAMPLE_HOLD_EN
                        sample_out_d    = sample_out_q;
`else
                        sample_out_d    = '0;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                wait_cnt_d = '0;
                state_d    = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                if (wait_cnt_q == WCW'(WAIT_LAST)) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_CAPTURE: begin
                // Strobe is registered, so it lands in the STROBE cycle.
                sample_out_d    = fif.fifo_dout;
                sample_strobe_d = 1'b1;
                state_d         = S_STROBE;
            end
            S_STROBE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fifo_rd_d = (state_d == S_REQ);
    end

    // State and output registers; reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            wait_cnt_q      <= '0;
            wr_prev_q       <= 1'b0;
            fifo_rd_q       <= 1'b0;
            sample_out_q    <= '0;
            sample_strobe_q <= 1'b0;
            level_q         <= '0;
            underrun_q      <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            wait_cnt_q      <= wait_cnt_d;
            wr_prev_q       <= wr_prev_d;
            fifo_rd_q       <= fifo_rd_d;
            sample_out_q    <= sample_out_d;
            sample_strobe_q <= sample_strobe_d;
            level_q         <= level_d;
            underrun_q      <= underrun_d;
            overflow_q      <= overflow_d;
        end
    end

    assign fif.fifo_rd    = fifo_rd_q;
    assign sample_out     = sample_out_q;
    assign sample_strobe  = sample_strobe_q;
    assign level          = level_q;
    assign underrun       = underrun_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_fifo_sample_reader.sv
// Directed bench for fifo_sample_reader (SAMPLE_PERIOD=8, DEPTH=4, RD_LAT=2)
// with a small FIFO read-latency model.
module tb_fifo_sample_reader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int SP    = 8;
    localparam int RDL   = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic             clr_overflow = 1'b0;
    logic [WIDTH-1:0] sample_out;
    logic             sample_strobe;
    logic [LW-1:0]    level;
    logic             underrun;
    logic             overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_sample_reader_if #(.WIDTH(WIDTH)) fif ();

    fifo_sample_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SAMPLE_PERIOD(SP), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr_overflow(clr_overflow),
        .fif(fif), .sample_out(sample_out), .sample_strobe(sample_strobe),
        .level(level), .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // FIFO model: the word addressed by a read pulse appears exactly RDL cycles later.
    logic [WIDTH-1:0] mem [0:7];
    logic [2:0]       rd_ptr;
    logic [WIDTH-1:0] stage1, dout_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 3'd0;
            stage1 <= 16'hDEAD;
            dout_q <= 16'hDEAD;
        end else begin
            stage1 <= fif.fifo_rd ? mem[rd_ptr] : 16'hDEAD;
            if (fif.fifo_rd) rd_ptr <= rd_ptr + 3'd1;
            dout_q <= stage1;
        end
    end
    assign fif.fifo_dout = dout_q;

    typedef struct {
        logic          wr;
        logic          clr;
        logic [LW-1:0] exp_level;
        logic          exp_ovf;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        clr_overflow = 1'b0;
        fif.fifo_wr_mon = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_edges(input int n);
        for (int k = 0; k < n; k++) begin
            fif.fifo_wr_mon = 1'b1;
            step();
            fif.fifo_wr_mon = 1'b0;
            step();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " fifo_rd"},       32'(fif.fifo_rd),     32'd0);
        chk({tag, " sample_out"},    32'(sample_out),      32'd0);
        chk({tag, " sample_strobe"}, 32'(sample_strobe),   32'd0);
        chk({tag, " level"},         32'(level),           32'd0);
        chk({tag, " underrun"},      32'(underrun),        32'd0);
        chk({tag, " overflow"},      32'(overflow),        32'd0);
    endtask

    logic [WIDTH-1:0] exp_so;
    logic [WIDTH-1:0] hold_or_zero;

    initial begin
        fif.fifo_wr_mon = 1'b0;
        for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
        #1;

        // 1: reset, then free-running with no writes -> periodic underrun.
        do_reset();
        chk_reset_vals("reset");
        enable = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            chk($sformatf("t1 underrun @%0d", i), 32'(underrun),      32'((i % 8) == 0));
            chk($sformatf("t1 strobe @%0d", i),   32'(sample_strobe), 32'((i % 8) == 0));
            chk($sformatf("t1 fifo_rd @%0d", i),  32'(fif.fifo_rd),   32'd0);
            chk($sformatf("t1 sample @%0d", i),   32'(sample_out),    32'd0);
        end

        // 2: three samples, then the fourth tick underruns.
        do_reset();
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        write_edges(3);
        chk("t2 level after writes", 32'(level), 32'd3);
`ifdef SAMPLE_HOLD_EN
        hold_or_zero = 16'h3333;
`else
        hold_or_zero = 16'h0000;
`endif
        enable = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            step();
            if (i < 11)      exp_so = 16'h0000;
            else if (i < 19) exp_so = 16'h1111;
            else if (i < 27) exp_so = 16'h2222;
            else if (i < 32) exp_so = 16'h3333;
            else             exp_so = hold_or_zero;
            chk($sformatf("t2 fifo_rd @%0d", i), 32'(fif.fifo_rd),
                32'(i == 8 || i == 16 || i == 24));
            chk($sformatf("t2 strobe @%0d", i), 32'(sample_strobe),
                32'(i == 11 || i == 19 || i == 27 || i == 32));
            chk($sformatf("t2 underrun @%0d", i), 32'(underrun), 32'(i == 32));
            chk($sformatf("t2 level @%0d", i), 32'(level),
                32'(3 - int'(i >= 9) - int'(i >= 17) - int'(i >= 25)));
            chk($sformatf("t2 sample @%0d", i), 32'(sample_out), 32'(exp_so));
        end

        // 3: table-driven saturation, overflow set and clear (set wins).
        do_reset();
        tbl[0]  = '{1'b1, 1'b0, 3'd1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd2, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd3, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3'd3, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd4, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd4, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'd4, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd4, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'd4, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 3'd4, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 3'd4, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 3'd4, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 3'd4, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 3'd4, 1'b0};
        for (int v = 0; v < 16; v++) begin
            fif.fifo_wr_mon = tbl[v].wr;
            clr_overflow    = tbl[v].clr;
            step();
            chk($sformatf("t3 level vec%0d", v),    32'(level),    32'(tbl[v].exp_level));
            chk($sformatf("t3 overflow vec%0d", v), 32'(overflow), 32'(tbl[v].exp_ovf));
        end
        clr_overflow = 1'b0;
        fif.fifo_wr_mon = 1'b0;

        // 4: write edge in the REQ cycle at level 2 leaves level at 2.
        do_reset();
        mem[0] = 16'hAAAA;
        write_edges(2);
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) step();
        chk("t4 fifo_rd in REQ", 32'(fif.fifo_rd), 32'd1);
        chk("t4 level in REQ", 32'(level), 32'd2);
        fif.fifo_wr_mon = 1'b1;
        step();
        chk("t4 level after coincident", 32'(level), 32'd2);
        fif.fifo_wr_mon = 1'b0;
        step();
        chk("t4 level settled", 32'(level), 32'd2);
        step();
        chk("t4 strobe", 32'(sample_strobe), 32'd1);
        chk("t4 sample", 32'(sample_out), 32'(16'hAAAA));

        // 5: last sample 0x7FFF followed by an underrun.
        do_reset();
        mem[0] = 16'h7FFF;
        write_edges(1);
        enable = 1'b1;
`ifdef SAMPLE_HOLD_EN
        hold_or_zero = 16'h7FFF;
`else
        hold_or_zero = 16'h0000;
`endif
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 11) begin
                chk("t5 strobe sample", 32'(sample_strobe), 32'd1);
                chk("t5 sample 7FFF", 32'(sample_out), 32'(16'h7FFF));
            end else if (i == 16) begin
                chk("t5 underrun", 32'(underrun), 32'd1);
                chk("t5 underrun strobe", 32'(sample_strobe), 32'd1);
                chk("t5 sample on underrun", 32'(sample_out), 32'(hold_or_zero));
                chk("t5 level", 32'(level), 32'd0);
            end
        end

        // 6: asynchronous reset during WAIT, then no strobe until the next tick.
        do_reset();
        mem[0] = 16'h1234; mem[1] = 16'h5678;
        write_edges(5);
        enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 11) chk("t6 first sample", 32'(sample_out), 32'(16'h1234));
        end
        chk("t6 level in WAIT", 32'(level), 32'd2);
        chk("t6 overflow pre-reset", 32'(overflow), 32'd1);
        chk("t6 fifo_rd in WAIT", 32'(fif.fifo_rd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6 async");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("t6 strobe @%0d", i),   32'(sample_strobe), 32'(i == 8));
            chk($sformatf("t6 underrun @%0d", i), 32'(underrun),      32'(i == 8));
            chk($sformatf("t6 fifo_rd @%0d", i),  32'(fif.fifo_rd),   32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
